// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared definitions for the memory port arbiter. Holds the
//               arbiter state encoding, the poison word returned on aborted
//               accesses, the default wait limit and the wait-counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        D_WAIT = 2'd1,
        I_WAIT = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    // Returned to the CPU in place of real data when memory never answers
    localparam logic [31:0] C_POISON          = 32'hDEADBEEF;
    localparam int          C_TIMEOUT_DEFAULT = 255;
    // Wide enough for the largest legal wait limit (65535)
    localparam int          C_CNT_W           = 16;

endpackage
`default_nettype wire

// File: rtl/mem_arb_timeout.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_timeout
// Description : Wait-cycle counter for one memory access. Cleared to zero by
//               i_clr, advanced by i_en. o_expire flags the cycle in which the
//               count would reach LIMIT, i.e. the LIMIT-th unanswered cycle.
// Ports       : clk, rst_n (async, active low), i_clr, i_en, o_expire
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_timeout
    import mem_arb_pkg::*;
#(
    parameter int LIMIT = C_TIMEOUT_DEFAULT,
    parameter int CNT_W = C_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_expire = i_en && (r_cnt == C_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares a single-ported memory between the CPU data port
//               (port 0, read/write) and the instruction-fetch port (port 1,
//               read-only). Requests of one CPU cycle are served data first,
//               then fetch; stall is held until both are done, then dropped
//               for one RESP cycle. Unanswered accesses are aborted after
//               TIMEOUT wait cycles, return 32'hDEADBEEF and set timeout_err.
// Ports       : clock, reset (async, active low)
//               CRead0/CWrite0/CAddr0/CWriteData0/CReadData0 - data port
//               CRead1/CAddr1/CReadData1                     - fetch port
//               stall                                        - CPU stall
//               MRead/MWrite/MAddr/MWriteData/MReadData/MReady - memory
//               timeout_err                                  - sticky abort
// Options     : MEM_ARB_PERF_EN adds perf_stall_cycles, perf_data_grants and
//               perf_fetch_grants (32-bit, wrapping) output counters.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = C_TIMEOUT_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              CRead0,
    input  logic              CWrite0,
    input  logic [ADDR_W-1:0] CAddr0,
    input  logic [DATA_W-1:0] CWriteData0,
    output logic [DATA_W-1:0] CReadData0,
    input  logic              CRead1,
    input  logic [ADDR_W-1:0] CAddr1,
    output logic [DATA_W-1:0] CReadData1,
    output logic              stall,
    output logic              MRead,
    output logic              MWrite,
    output logic [ADDR_W-1:0] MAddr,
    output logic [DATA_W-1:0] MWriteData,
    input  logic [DATA_W-1:0] MReadData,
    input  logic              MReady,
    output logic              timeout_err
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_stall_cycles,
    output logic [31:0]       perf_data_grants,
    output logic [31:0]       perf_fetch_grants
`endif
);

    localparam logic [DATA_W-1:0] C_POISON_W = DATA_W'(C_POISON);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_op_write;
    logic              r_d_done;
    logic              r_i_done;

    logic w_data_req;
    logic w_in_wait;
    logic w_cnt_en;
    logic w_cnt_clr;
    logic w_expire;
    logic w_done;

    assign w_data_req = CRead0 | CWrite0;
    assign w_in_wait  = (r_state == D_WAIT) || (r_state == I_WAIT);
    assign w_cnt_en   = w_in_wait && !MReady;
    // A ready or aborted access leaves its wait state, so clearing on
    // completion leaves the counter at zero for the next wait state.
    assign w_done     = w_in_wait && (MReady || w_expire);
    assign w_cnt_clr  = !w_in_wait || w_done;
    assign MWriteData = r_wdata;

    mem_arb_timeout #(
        .LIMIT (TIMEOUT),
        .CNT_W (C_CNT_W)
    ) u_timeout (
        .clk      (clock),
        .rst_n    (reset),
        .i_clr    (w_cnt_clr),
        .i_en     (w_cnt_en),
        .o_expire (w_expire)
    );

    always_comb begin
        w_state_nxt = r_state;
        stall       = 1'b0;
        MRead       = 1'b0;
        MWrite      = 1'b0;
        MAddr       = '0;
        case (r_state)
            IDLE: begin
                // Gated by reset so the CPU is released while reset is held
                stall = reset && (w_data_req || CRead1);
                if (w_data_req && !r_d_done) begin
                    w_state_nxt = D_WAIT;
                end else if (CRead1 && !r_i_done) begin
                    w_state_nxt = I_WAIT;
                end
            end
            D_WAIT: begin
                stall  = 1'b1;
                MWrite = r_op_write;
                MRead  = !r_op_write;
                MAddr  = r_addr;
                if (w_done) begin
                    w_state_nxt = (CRead1 && !r_i_done) ? I_WAIT : RESP;
                end
            end
            I_WAIT: begin
                stall = 1'b1;
                MRead = 1'b1;
                MAddr = CAddr1;
                if (w_done) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_op_write  <= 1'b0;
            r_d_done    <= 1'b0;
            r_i_done    <= 1'b0;
            CReadData0  <= '0;
            CReadData1  <= '0;
            timeout_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == IDLE) && w_data_req) begin
                r_addr     <= CAddr0;
                r_wdata    <= CWriteData0;
                // Write takes priority over a simultaneous read
                r_op_write <= CWrite0;
            end
            if ((r_state == D_WAIT) && w_done) begin
                r_d_done <= 1'b1;
                if (MReady) begin
                    if (!r_op_write) begin
                        CReadData0 <= MReadData;
                    end
                end else begin
                    CReadData0  <= C_POISON_W;
                    timeout_err <= 1'b1;
                end
            end
            if ((r_state == I_WAIT) && w_done) begin
                r_i_done <= 1'b1;
                if (MReady) begin
                    CReadData1 <= MReadData;
                end else begin
                    CReadData1  <= C_POISON_W;
                    timeout_err <= 1'b1;
                end
            end
            if (r_state == RESP) begin
                r_d_done <= 1'b0;
                r_i_done <= 1'b0;
            end
        end
    end

`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_stall_cycles <= '0;
            perf_data_grants  <= '0;
            perf_fetch_grants <= '0;
        end else begin
            if (stall) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            if ((w_state_nxt == D_WAIT) && (r_state != D_WAIT)) begin
                perf_data_grants <= perf_data_grants + 32'd1;
            end
            if ((w_state_nxt == I_WAIT) && (r_state != I_WAIT)) begin
                perf_fetch_grants <= perf_fetch_grants + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter. A transaction-level
//               model predicts the memory access sequence, stall timeline,
//               returned data and the sticky error flag; memory is a sparse
//               array owned by the bench.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 6;

    logic          clock = 1'b0;
    logic          reset;
    logic          CRead0, CWrite0, CRead1;
    logic [AW-1:0] CAddr0, CAddr1;
    logic [DW-1:0] CWriteData0, CReadData0, CReadData1;
    logic          stall, MRead, MWrite, MReady, timeout_err;
    logic [AW-1:0] MAddr;
    logic [DW-1:0] MWriteData, MReadData;
`ifdef MEM_ARB_PERF_EN
    logic [31:0]   perf_stall_cycles, perf_data_grants, perf_fetch_grants;
`endif

    always #5 clock = ~clock;

    mem_port_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .CRead0      (CRead0),
        .CWrite0     (CWrite0),
        .CAddr0      (CAddr0),
        .CWriteData0 (CWriteData0),
        .CReadData0  (CReadData0),
        .CRead1      (CRead1),
        .CAddr1      (CAddr1),
        .CReadData1  (CReadData1),
        .stall       (stall),
        .MRead       (MRead),
        .MWrite      (MWrite),
        .MAddr       (MAddr),
        .MWriteData  (MWriteData),
        .MReadData   (MReadData),
        .MReady      (MReady),
        .timeout_err (timeout_err)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_data_grants  (perf_data_grants),
        .perf_fetch_grants (perf_fetch_grants)
`endif
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] mem [logic [31:0]];
    logic [31:0] exp_rd0, exp_rd1;
    logic        exp_err;
    int          exp_stall, exp_dg, exp_fg;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[15:0], 16'hC0DE};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One memory access: expected to last until MReady or TO wait cycles.
    task automatic do_access(input bit is_wr, input logic [31:0] addr, input logic [31:0] wd,
                             input int delay, output logic [31:0] rdata, output bit aborted);
        int w;
        w = (delay < TO) ? delay + 1 : TO;
        for (int j = 0; j < w; j++) begin
            @(negedge clock);
            chk("stall_wait", stall, 1'b1);
            chk("mread", MRead, !is_wr);
            chk("mwrite", MWrite, is_wr);
            chk("maddr", MAddr, addr);
            if (is_wr) chk("mwdata", MWriteData, wd);
            if (j == delay) begin
                MReady    = 1'b1;
                MReadData = is_wr ? $urandom : mem_rd(addr);
            end else begin
                MReady    = 1'b0;
                MReadData = $urandom;
            end
            @(posedge clock);
            #1;
            MReady = 1'b0;
        end
        aborted = (delay >= TO);
        rdata   = aborted ? 32'hDEADBEEF : mem_rd(addr);
        if (!aborted && is_wr) mem[addr] = wd;
        exp_stall += w;
    endtask

    // One CPU cycle's worth of requests; called just after a rising edge.
    task automatic run_txn(input bit rd0, input bit wr0, input bit rd1,
                           input logic [31:0] a0, input logic [31:0] wd0, input logic [31:0] a1,
                           input int dd, input int id);
        logic [31:0] rv;
        bit          ab;
        bit          any;
        any         = rd0 | wr0 | rd1;
        CRead0      = rd0;
        CWrite0     = wr0;
        CRead1      = rd1;
        CAddr0      = a0;
        CWriteData0 = wd0;
        CAddr1      = a1;
        @(negedge clock);
        chk("stall_idle", stall, any);
        chk("mread_idle", MRead, 1'b0);
        chk("mwrite_idle", MWrite, 1'b0);
        if (any) exp_stall++;
        @(posedge clock);
        #1;
        if (!any) return;
        if (rd0 | wr0) begin
            exp_dg++;
            do_access(wr0, a0, wd0, dd, rv, ab);
            if (ab) exp_err = 1'b1;
            if (ab || !wr0) exp_rd0 = rv;
        end
        if (rd1) begin
            exp_fg++;
            do_access(1'b0, a1, 32'd0, id, rv, ab);
            if (ab) exp_err = 1'b1;
            exp_rd1 = rv;
        end
        @(negedge clock);
        chk("stall_resp", stall, 1'b0);
        chk("mread_resp", MRead, 1'b0);
        chk("mwrite_resp", MWrite, 1'b0);
        chk("creaddata0", CReadData0, exp_rd0);
        chk("creaddata1", CReadData1, exp_rd1);
        chk("timeout_err", timeout_err, exp_err);
        @(posedge clock);
        #1;
        CRead0  = 1'b0;
        CWrite0 = 1'b0;
        CRead1  = 1'b0;
    endtask

    initial begin
        int op, dd, id;
        reset       = 1'b0;
        CRead0      = 1'b0;
        CWrite0     = 1'b0;
        CRead1      = 1'b0;
        CAddr0      = '0;
        CAddr1      = '0;
        CWriteData0 = '0;
        MReady      = 1'b0;
        MReadData   = '0;
        exp_rd0     = '0;
        exp_rd1     = '0;
        exp_err     = 1'b0;
        exp_stall   = 0;
        exp_dg      = 0;
        exp_fg      = 0;

        @(negedge clock);
        chk("rst_stall", stall, 1'b0);
        chk("rst_strobes", {MRead, MWrite}, 2'b00);
        chk("rst_maddr", MAddr, 32'd0);
        chk("rst_mwdata", MWriteData, 32'd0);
        chk("rst_rdata", {CReadData0, CReadData1}, 64'd0);
        chk("rst_err", timeout_err, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;

        // Fetch only, immediate ready
        mem[32'h10] = 32'h8C010004;
        run_txn(0, 0, 1, 32'h0, 32'h0, 32'h10, 0, 0);
        chk("fetch_value", CReadData1, 32'h8C010004);
        // Write then fetch; read data must stay unchanged
        run_txn(0, 1, 1, 32'h40, 32'h12345678, 32'h14, 0, 0);
        // Read with ready on the 6th wait cycle (coincides with the limit)
        run_txn(1, 0, 0, 32'h40, 32'h0, 32'h0, 5, 0);
        chk("delayed_read", CReadData0, 32'h12345678);
        // Read and write together: write wins
        run_txn(1, 1, 0, 32'h48, 32'hCAFEF00D, 32'h0, 1, 0);
        // Memory never answers: abort
        run_txn(1, 0, 1, 32'h44, 32'h0, 32'h18, TO + 3, 0);
        chk("abort_value", CReadData0, 32'hDEADBEEF);
        // CPU halted: no requests
        run_txn(0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
        // Error stays set into a clean transaction
        run_txn(0, 0, 1, 32'h0, 32'h0, 32'h10, 0, 0);

        for (int n = 0; n < 40; n++) begin
            op = $urandom_range(0, 7);
            dd = ($urandom_range(0, 5) == 0) ? $urandom_range(TO - 1, TO + 1) : $urandom_range(0, 2);
            id = ($urandom_range(0, 5) == 0) ? $urandom_range(TO - 1, TO + 1) : $urandom_range(0, 2);
            run_txn(op[0], op[1], op[2], {26'd0, 4'($urandom_range(0, 15)), 2'b00}, $urandom,
                    {26'd0, 4'($urandom_range(0, 15)), 2'b00}, dd, id);
        end

        // Reset in the middle of a data access
        CRead0 = 1'b1;
        CAddr0 = 32'h80;
        CRead1 = 1'b1;
        CAddr1 = 32'h84;
        @(posedge clock);
        #1;
        @(posedge clock);
        #2;
        chk("pre_rst_mread", MRead, 1'b1);
        reset = 1'b0;
        #1;
        chk("midrst_stall", stall, 1'b0);
        chk("midrst_strobes", {MRead, MWrite}, 2'b00);
        chk("midrst_rdata", {CReadData0, CReadData1}, 64'd0);
        chk("midrst_err", timeout_err, 1'b0);
        CRead0    = 1'b0;
        CRead1    = 1'b0;
        exp_rd0   = '0;
        exp_rd1   = '0;
        exp_err   = 1'b0;
        exp_stall = 0;
        exp_dg    = 0;
        exp_fg    = 0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        mem[32'h20] = 32'h0BADF00D;
        run_txn(0, 0, 1, 32'h0, 32'h0, 32'h20, 0, 0);
        run_txn(0, 0, 1, 32'h0, 32'h0, 32'h10, 0, 0);
        run_txn(0, 0, 1, 32'h0, 32'h0, 32'h20, 0, 0);
        chk("post_rst_fetch", CReadData1, 32'h0BADF00D);
`ifdef MEM_ARB_PERF_EN
        chk("perf_stall", perf_stall_cycles, 32'(exp_stall));
        chk("perf_dgrant", perf_data_grants, 32'(exp_dg));
        chk("perf_fgrant", perf_fetch_grants, 32'(exp_fg));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
